// File: rtl/reg_dump_reader_pkg.sv
// reg_dump_reader_pkg: shared constants and FSM state encoding for the register dump reader.
package reg_dump_reader_pkg;

    localparam int WORD_LEN   = 32;
    localparam int WORD_COUNT = 16;
    localparam int IDX_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } dumpState_e;

endpackage

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a wrapping register index range through read port 1 and streams each value out.
module reg_dump_reader #(
    parameter int WORD_LEN   = reg_dump_reader_pkg::WORD_LEN,
    parameter int WORD_COUNT = reg_dump_reader_pkg::WORD_COUNT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                abort,
    input  logic [reg_dump_reader_pkg::IDX_W-1:0] firstReg,
    input  logic [reg_dump_reader_pkg::IDX_W-1:0] lastReg,
    output logic                                regRead,
    output logic [reg_dump_reader_pkg::IDX_W-1:0] readRegister,
    input  logic [WORD_LEN-1:0]                 readData,
    output logic                                outValid,
    input  logic                                outReady,
    output logic [WORD_LEN-1:0]                 outData,
    output logic [reg_dump_reader_pkg::IDX_W-1:0] outIndex,
    output logic                                busy,
    output logic                                done
);
    import reg_dump_reader_pkg::*;

    dumpState_e       state, nextState;
    logic [IDX_W-1:0] idx, last, idxNext;
    logic             xfer;

    assign xfer    = (state == SEND) && outReady;
    assign idxNext = (idx == IDX_W'(WORD_COUNT - 1)) ? '0 : idx + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            last     <= '0;
            outData  <= '0;
            outIndex <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && start) begin
                idx  <= firstReg;
                last <= lastReg;
            end
            if (state == READ && !abort) begin
                outData  <= readData;
                outIndex <= idx;
            end
            // an aborted or final transfer leaves idx where it is
            if (xfer && !abort && idx != last)
                idx <= idxNext;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: nextState = start ? READ : IDLE;
            READ: nextState = abort ? DONE : SEND;
            SEND: nextState = abort ? DONE : !outReady ? SEND : (idx == last) ? DONE : READ;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        regRead      = state == READ;
        outValid     = state == SEND;
        busy         = state != IDLE;
        done         = state == DONE;
        readRegister = idx;
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: vector-table and directed-sequence bench for reg_dump_reader.
module tb_reg_dump_reader;

    typedef struct {
        logic [3:0] first;
        logic [3:0] last;
        int         cnt;
        int         stallIdx;
        int         startPulse;
        int         wrCycle;
    } vec_t;

    logic        clk = 0, rst = 1, start = 0, abort = 0, outReady = 1;
    logic [3:0]  firstReg = 0, lastReg = 0;
    logic        regRead, outValid, busy, done;
    logic [3:0]  readRegister, outIndex;
    logic [31:0] readData, outData;
    logic [31:0] mem [16];
    int          checks = 0, errors = 0;
    vec_t        vecs [7];
    vec_t        again;

    assign readData = mem[readRegister];

    always #5 clk = ~clk;

    reg_dump_reader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .firstReg(firstReg), .lastReg(lastReg),
        .regRead(regRead), .readRegister(readRegister), .readData(readData),
        .outValid(outValid), .outReady(outReady), .outData(outData),
        .outIndex(outIndex), .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic doDump(input vec_t v);
        int         cyc, cnt, stalls;
        logic [31:0] holdData;
        logic [3:0]  holdIdx, expIdx;
        firstReg = v.first;
        lastReg  = v.last;
        start    = 1;
        outReady = 1;
        tick();
        start    = 0;
        firstReg = ~v.first;
        lastReg  = v.first;
        cyc = 1; cnt = 0; stalls = 0;
        holdData = '0; holdIdx = '0;
        while (!done && cyc < 200) begin
            if (cyc == v.startPulse) begin
                start = 1; firstReg = 4'd9; lastReg = 4'd9;
            end else
                start = 0;
            if (cyc == v.wrCycle) begin
                @(negedge clk);
                mem[5] = 32'hDEADBEEF;
            end
            expIdx = v.first + 4'(cnt);
            if (outValid && 32'(outIndex) == v.stallIdx && stalls < 5) begin
                if (stalls == 0) begin
                    holdData = outData; holdIdx = outIndex;
                end else begin
                    chk("stall_data", outData, holdData);
                    chk("stall_idx", 32'(outIndex), 32'(holdIdx));
                end
                chk("stall_regRead", 32'(regRead), 0);
                outReady = 0;
                stalls++;
            end else begin
                outReady = 1;
                if (outValid) begin
                    chk("out_idx", 32'(outIndex), 32'(expIdx));
                    chk("out_data", outData, mem[expIdx]);
                    chk("valid_time", cyc, 2 * cnt + 2 + stalls);
                    cnt++;
                end else begin
                    chk("read_en", 32'(regRead), 1);
                    chk("read_addr", 32'(readRegister), 32'(expIdx));
                end
            end
            tick();
            cyc++;
        end
        start = 0;
        chk("done_seen", 32'(done), 1);
        chk("done_time", cyc, 2 * v.cnt + 1 + stalls);
        chk("xfer_count", cnt, v.cnt);
        tick();
        chk("busy_after", 32'(busy), 0);
        chk("done_pulse", 32'(done), 0);
    endtask

    task automatic chkReset(input string tag);
        chk({tag, "_regRead"}, 32'(regRead), 0);
        chk({tag, "_readRegister"}, 32'(readRegister), 0);
        chk({tag, "_outValid"}, 32'(outValid), 0);
        chk({tag, "_outData"}, outData, 0);
        chk({tag, "_outIndex"}, 32'(outIndex), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) mem[i] = 32'(i);
        vecs[0] = '{4'd0,  4'd3, 4,  -1, 0, 0};
        vecs[1] = '{4'd14, 4'd1, 4,  -1, 0, 0};
        vecs[2] = '{4'd7,  4'd7, 1,  -1, 0, 0};
        vecs[3] = '{4'd0,  4'd4, 5,   2, 0, 0};
        vecs[4] = '{4'd10, 4'd12, 3, -1, 3, 0};
        vecs[5] = '{4'd4,  4'd6, 3,  -1, 0, 3};
        vecs[6] = '{4'd9,  4'd8, 16, -1, 0, 0};
        again   = '{4'd2,  4'd3, 2,  -1, 0, 0};

        #2 rst = 0;
        #1 chkReset("reset");
        #5 rst = 1;
        tick();
        tick();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_regRead", 32'(regRead), 0);

        for (int v = 0; v < 7; v++) begin
            doDump(vecs[v]);
            if (v == 0)
                for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE0000 + 32'(i) * 32'h00010101;
        end

        // abort while stalled in SEND
        firstReg = 4'd0; lastReg = 4'd5; outReady = 0; start = 1;
        tick();
        start = 0;
        n = 0;
        while (!outValid && n < 10) begin
            tick();
            n++;
        end
        chk("abort_reach_send", 32'(outValid), 1);
        abort = 1;
        tick();
        abort = 0;
        chk("abort_send_valid", 32'(outValid), 0);
        chk("abort_send_done", 32'(done), 1);
        chk("abort_send_regRead", 32'(regRead), 0);
        tick();
        chk("abort_send_idle", 32'(busy), 0);
        outReady = 1;

        // abort during READ
        firstReg = 4'd2; lastReg = 4'd3; start = 1;
        tick();
        start = 0;
        chk("abort_read_state", 32'(regRead), 1);
        abort = 1;
        tick();
        abort = 0;
        chk("abort_read_done", 32'(done), 1);
        chk("abort_read_valid", 32'(outValid), 0);
        chk("abort_read_regRead", 32'(regRead), 0);
        tick();
        chk("abort_read_idle", 32'(busy), 0);

        doDump(again);

        // asynchronous reset in the middle of SEND
        firstReg = 4'd3; lastReg = 4'd5; outReady = 0; start = 1;
        tick();
        start = 0;
        tick();
        chk("rst_mid_send_valid", 32'(outValid), 1);
        #2 rst = 0;
        #1 chkReset("rst_mid");
        #1 rst = 1;
        outReady = 1;
        tick();
        chk("rst_mid_after_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Sequential debug reader for the 16-entry register file. On a start command it walks a contiguous, optionally wrapping range of register indices through the file's read port, one register per transfer. Each value goes out on a valid/ready stream to the debug/trace path. It sits beside the decode stage and drives read port 1 only while the pipeline is stalled for debug.

## Interface
Parameters:
- WORD_LEN, 32, register data width
- WORD_COUNT, 16, number of registers; index width IDX_W = 4, fixed by the file's 4-bit address

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset; 0 clears all state immediately
- start  input  1  one-cycle request; sampled only in IDLE
- abort  input  1  cancels an active dump
- firstReg  input  4  first index of range, captured on accepted start
- lastReg  input  4  last index of range (inclusive), captured on accepted start
- regRead  output  1  read enable to register file
- readRegister  output  4  read address to register file
- readData  input  WORD_LEN  read data from register file (combinational)
- outValid  output  1  outData/outIndex valid
- outReady  input  1  consumer accepts when high with outValid
- outData  output  WORD_LEN  captured register value
- outIndex  output  4  index of outData
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse on range completion or abort

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: start=1 captures firstReg into idx and lastReg into last, then goes to READ. In IDLE, start=0 keeps the block in IDLE.
- READ: regRead=1, readRegister=idx. At posedge, outData<=readData and outIndex<=idx, then go to SEND.
- SEND: outValid=1 and regRead=0. While outReady=0, hold outData and outIndex stable and stay in SEND.
- SEND handshake: on outValid&&outReady, if idx==last go to DONE. Otherwise idx<=idx+1 mod WORD_COUNT (15 wraps to 0) and go to READ.
- Wrap: if firstReg>lastReg, the range wraps (e.g. 14,15,0,1). firstReg==lastReg dumps exactly one register. A full 16-register dump is expressed as lastReg=firstReg-1 mod 16.
- DONE: done=1 for one cycle, then go to IDLE.
- abort: takes effect in READ or SEND. Next state is DONE, outValid drops in that next cycle, and no further reads occur. A transfer completing in the same cycle as abort counts as delivered. abort in IDLE or DONE is ignored.
- start while busy is ignored; it is not queued.
- readRegister holds idx in all states; regRead=0 outside READ.

## Timing
- Reset values: regRead=0, readRegister=0, outValid=0, outData=0, outIndex=0, busy=0, done=0, state=IDLE, idx=0, last=0.
- Start sampled at edge N: READ is cycle N+1 and outValid first rises in cycle N+2.
- Each register costs 2 cycles with outReady held high. A K-register dump takes 2K cycles from the start edge, then one DONE cycle.
- Register file writes land on negedge. A write landing before the READ posedge is captured, since read data is combinational.
- rst asserted mid-dump returns the block to reset values asynchronously; the partial transfer is discarded.

## Structure
- Shared package: WORD_LEN, WORD_COUNT, IDX_W constants, and the state enum {IDLE, READ, SEND, DONE}.
- No sub-module. The wrapping index counter is inline in the single always block.

## Test plan
- Reset then start, first=0, last=3, outReady=1: indices 0,1,2,3 out with values 0..3 (file init), outValid rising every 2 cycles; done pulse in cycle 9 after the start edge; busy low after.
- Wrap, first=14, last=1: outIndex sequence 14,15,0,1. Single, first=last=7: exactly one transfer, then done.
- Backpressure: outReady low for 5 cycles on index 2. outData/outIndex stay stable and regRead stays 0 during the stall; the sequence resumes without loss.
- abort in SEND with outReady=0: next cycle outValid=0 and done=1, then IDLE. A second start is accepted normally.
- start pulsed while busy: ignored, and the sequence is unchanged. A negedge write of 0xDEADBEEF to r5 before READ of idx 5: outData=0xDEADBEEF.
- rst low mid-SEND: all outputs return to reset values without waiting for a clock edge.
